song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_pkg.sv | 27 ++
 rtl/song_rom.sv | 80 ++++++++
 rtl/song_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_song_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/song_pkg.sv
// Shared types and constants for the song sequencer: state encoding,
// field widths of the song ROM word and a word-packing helper.
package song_pkg;

  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 4;
  localparam int ADDR_W    = 6;
  localparam int WORD_W    = NOTE_W + DUR_W;
  localparam int NUM_SONGS = 10;

  // A duration of zero marks the end of a song.
  localparam logic [DUR_W-1:0] END_DUR = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_NOTE  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic [WORD_W-1:0] mk_word(input logic [NOTE_W-1:0] note,
                                                input logic [DUR_W-1:0]  dur);
    return {note, dur};
  endfunction

endpackage

// File: rtl/song_rom.sv
// Registered song ROM. Word = {note_code, dur}; dur == 0 is the end marker.
// Song 9 is a generated 64-note ramp with no end marker, so the end of the
// address space terminates it. Indices 10..15 return an end marker everywhere.
module song_rom
  import song_pkg::*;
(
  input  logic              clk,
  input  logic [3:0]        song_index,
  input  logic [ADDR_W-1:0] note_addr,
  output logic [WORD_W-1:0] data
);

  function automatic logic [WORD_W-1:0] lookup(input logic [3:0]        s,
                                               input logic [ADDR_W-1:0] a);
    logic [WORD_W-1:0] w;
    w = '0;
    case (s)
      4'd0: case (a)
        6'd0:    w = mk_word(6'd12, 4'd2);
        6'd1:    w = mk_word(6'd14, 4'd1);
        6'd2:    w = mk_word(6'd0,  4'd1);
        6'd3:    w = mk_word(6'd16, 4'd1);
        6'd4:    w = mk_word(6'd17, 4'd1);
        6'd5:    w = mk_word(6'd19, 4'd3);
        6'd6:    w = mk_word(6'd21, 4'd1);
        default: w = '0;
      endcase
      4'd1: case (a)
        6'd0:    w = mk_word(6'd20, 4'd1);
        6'd1:    w = mk_word(6'd22, 4'd1);
        6'd2:    w = mk_word(6'd24, 4'd1);
        default: w = '0;
      endcase
      4'd2: case (a)
        6'd0:    w = mk_word(6'd10, 4'd1);
        6'd1:    w = mk_word(6'd11, 4'd1);
        default: w = '0;
      endcase
      4'd3: case (a)
        6'd0:    w = mk_word(6'd30, 4'd2);
        6'd1:    w = mk_word(6'd31, 4'd2);
        default: w = '0;
      endcase
      4'd4: case (a)
        6'd0:    w = mk_word(6'd40, 4'd1);
        6'd1:    w = mk_word(6'd41, 4'd1);
        default: w = '0;
      endcase
      4'd5: case (a)
        6'd0:    w = mk_word(6'd25, 4'd1);
        6'd1:    w = mk_word(6'd27, 4'd1);
        default: w = '0;
      endcase
      4'd6: case (a)
        6'd0:    w = mk_word(6'd33, 4'd2);
        default: w = '0;
      endcase
      4'd7: case (a)
        6'd0:    w = mk_word(6'd0,  4'd2);
        6'd1:    w = mk_word(6'd35, 4'd1);
        default: w = '0;
      endcase
      4'd8: case (a)
        6'd0:    w = mk_word(6'd45, 4'd1);
        6'd1:    w = mk_word(6'd47, 4'd1);
        6'd2:    w = mk_word(6'd48, 4'd2);
        default: w = '0;
      endcase
      4'd9:    w = mk_word(a, 4'd1);
      default: w = '0;
    endcase
    return w;
  endfunction

  // One-cycle read latency.
  always_ff @(posedge clk) begin
    data <= lookup(song_index, note_addr);
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks a song in song_rom and drives the tone generator.
// Optional macro SONG_LOOP_EN: the end of a song restarts it from note 0
// instead of parking in DONE.
//
// state | meaning
// IDLE  | silent, waiting for play
// FETCH | one cycle, ROM word for note_addr is being read
// NOTE  | note sounding, beat counter running
// HOLD  | paused, counters and address frozen, tone muted
// DONE  | end of song reached, silent
module song_sequencer
  import song_pkg::*;
#(
  parameter int CLKS_PER_BEAT = 12500000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              play,
  input  logic              pause,
  input  logic              restart,
  input  logic [3:0]        song_index,
  output logic [NOTE_W-1:0] note_code,
  output logic              tone_en,
  output logic [ADDR_W-1:0] note_addr,
  output logic              beat_tick,
  output logic              song_done
);

  localparam logic [2:0]  S_IDLE  = ST_IDLE;
  localparam logic [2:0]  S_FETCH = ST_FETCH;
  localparam logic [2:0]  S_NOTE  = ST_NOTE;
  localparam logic [2:0]  S_HOLD  = ST_HOLD;
  localparam logic [2:0]  S_DONE  = ST_DONE;
  localparam logic [23:0] BEAT_TC = 24'(CLKS_PER_BEAT - 1);

  logic [2:0]        state, state_n;
  logic [3:0]        song_idx_q;
  logic [23:0]       beat_cnt, cnt_n;
  logic [DUR_W-1:0]  remaining, rem_n;
  logic [ADDR_W-1:0] addr_n;
  logic [NOTE_W-1:0] code_n;
  logic              tone_n, tick_n, done_n;
  logic              end_hit, idle_hit;
  logic [WORD_W-1:0] rom_word;
  logic [NOTE_W-1:0] rom_note;
  logic [DUR_W-1:0]  rom_dur;

  assign rom_note = rom_word[WORD_W-1:DUR_W];
  assign rom_dur  = rom_word[DUR_W-1:0];

  // The ROM is addressed with next-cycle values so the word for the new
  // address is already valid during the single FETCH cycle.
  song_rom u_rom (
    .clk        (clk),
    .song_index (song_index),
    .note_addr  (addr_n),
    .data       (rom_word)
  );

  // Next-state and next-output decode; restart and song change win over all.
  always_comb begin
    state_n  = state;
    addr_n   = note_addr;
    code_n   = note_code;
    tone_n   = tone_en;
    cnt_n    = beat_cnt;
    rem_n    = remaining;
    tick_n   = 1'b0;
    done_n   = 1'b0;
    end_hit  = 1'b0;
    idle_hit = 1'b0;

    if (state != S_IDLE && (restart || song_index != song_idx_q)) begin
      state_n = S_FETCH;
      addr_n  = '0;
      cnt_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          idle_hit = 1'b1;
          if (play) begin
            idle_hit = 1'b0;
            state_n  = S_FETCH;
            addr_n   = '0;
            cnt_n    = '0;
          end
        end
        S_FETCH: begin
          if (rom_dur == END_DUR) begin
            end_hit = 1'b1;
          end else begin
            code_n = rom_note;
            rem_n  = rom_dur;
            cnt_n  = '0;
            if (pause) begin
              state_n = S_HOLD;
              tone_n  = 1'b0;
            end else begin
              state_n = S_NOTE;
              tone_n  = (rom_note != '0);
            end
          end
        end
        S_NOTE: begin
          if (!play && !pause) begin
            idle_hit = 1'b1;
          end else if (pause) begin
            state_n = S_HOLD;
            tone_n  = 1'b0;
          end else if (beat_cnt == BEAT_TC) begin
            tick_n = 1'b1;
            cnt_n  = '0;
            rem_n  = remaining - 1'b1;
            if (remaining == 4'd1) begin
              if (note_addr == {ADDR_W{1'b1}}) begin
                end_hit = 1'b1;
              end else begin
                state_n = S_FETCH;
                addr_n  = note_addr + 1'b1;
              end
            end
          end else begin
            cnt_n = beat_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (!play && !pause) begin
            idle_hit = 1'b1;
          end else if (play && !pause) begin
            state_n = S_NOTE;
            tone_n  = (note_code != '0);
          end
        end
        S_DONE: begin
          if (!play && !pause) idle_hit = 1'b1;
        end
        default: idle_hit = 1'b1;
      endcase

      if (end_hit) begin
        done_n = 1'b1;
        code_n = '0;
        tone_n = 1'b0;
        cnt_n  = '0;
        rem_n  = '0;
`ifdef SONG_LOOP_EN
        state_n = S_FETCH;
        addr_n  = '0;
`else
        state_n = S_DONE;
`endif
      end

      if (idle_hit) begin
        state_n = S_IDLE;
        addr_n  = '0;
        code_n  = '0;
        tone_n  = 1'b0;
        cnt_n   = '0;
        rem_n   = '0;
      end
    end
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      song_idx_q <= '0;
      beat_cnt   <= '0;
      remaining  <= '0;
      note_addr  <= '0;
      note_code  <= '0;
      tone_en    <= 1'b0;
      beat_tick  <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_n;
      song_idx_q <= song_index;
      beat_cnt   <= cnt_n;
      remaining  <= rem_n;
      note_addr  <= addr_n;
      note_code  <= code_n;
      tone_en    <= tone_n;
      beat_tick  <= tick_n;
      song_done  <= done_n;
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with CLKS_PER_BEAT=4.
// Expectations for the end-of-song behaviour follow SONG_LOOP_EN.
module tb_song_sequencer;

  logic       clk = 1'b0;
  logic       resetn, play, pause, restart;
  logic [3:0] song_index;
  logic [5:0] note_code, note_addr;
  logic       tone_en, beat_tick, song_done;

  int n_checks = 0;
  int n_errs   = 0;
  int pulses;

`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  song_sequencer #(.CLKS_PER_BEAT(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .play       (play),
    .pause      (pause),
    .restart    (restart),
    .song_index (song_index),
    .note_code  (note_code),
    .tone_en    (tone_en),
    .note_addr  (note_addr),
    .beat_tick  (beat_tick),
    .song_done  (song_done)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; play = 1'b0; pause = 1'b0; restart = 1'b0; song_index = 4'd0;
    cyc(3);
    check("rst_code", 32'(note_code), 0);
    check("rst_tone", 32'(tone_en), 0);
    check("rst_addr", 32'(note_addr), 0);
    check("rst_tick", 32'(beat_tick), 0);
    check("rst_done", 32'(song_done), 0);

    // first note of song 0 = {12,2}
    resetn = 1'b1; play = 1'b1;
    cyc(1);
    check("fetch_tone", 32'(tone_en), 0);
    check("fetch_addr", 32'(note_addr), 0);
    cyc(1);
    check("n0_tone", 32'(tone_en), 1);
    check("n0_code", 32'(note_code), 12);
    cyc(3);
    check("tick_pre", 32'(beat_tick), 0);
    cyc(1);
    check("tick_1", 32'(beat_tick), 1);
    check("tick_1_addr", 32'(note_addr), 0);
    cyc(1);
    check("tick_post", 32'(beat_tick), 0);
    cyc(2);
    check("n0_addr_hold", 32'(note_addr), 0);
    cyc(1);
    check("tick_2", 32'(beat_tick), 1);
    check("addr_1", 32'(note_addr), 1);
    cyc(1);
    check("n1_code", 32'(note_code), 14);
    cyc(5);
    check("rest_code", 32'(note_code), 0);
    check("rest_tone", 32'(tone_en), 0);
    check("rest_addr", 32'(note_addr), 2);
    cyc(15);
    check("n5_code", 32'(note_code), 19);
    check("n5_addr", 32'(note_addr), 5);
    check("n5_tone", 32'(tone_en), 1);

    // pause two cycles into the 3-beat note
    cyc(2);
    pause = 1'b1;
    cyc(1);
    check("hold_tone", 32'(tone_en), 0);
    check("hold_code", 32'(note_code), 19);
    check("hold_addr", 32'(note_addr), 5);
    cyc(9);
    check("hold10_tone", 32'(tone_en), 0);
    check("hold10_addr", 32'(note_addr), 5);
    check("hold10_tick", 32'(beat_tick), 0);
    pause = 1'b0;
    cyc(1);
    check("resume_tone", 32'(tone_en), 1);
    cyc(1);
    check("resume_tick0", 32'(beat_tick), 0);
    cyc(1);
    check("resume_tick1", 32'(beat_tick), 1);
    check("resume_addr", 32'(note_addr), 5);
    cyc(7);
    check("n5_last_addr", 32'(note_addr), 5);
    cyc(1);
    check("n6_addr", 32'(note_addr), 6);
    check("n6_tick", 32'(beat_tick), 1);
    cyc(1);
    check("n6_code", 32'(note_code), 21);

    // restart while sounding
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("rs_addr", 32'(note_addr), 0);
    cyc(1);
    check("rs_code", 32'(note_code), 12);
    cyc(29);
    check("rs_n5_addr", 32'(note_addr), 5);
    check("rs_n5_code", 32'(note_code), 19);

    // restart during pause at addr 5
    pause = 1'b1;
    cyc(1);
    check("p5_tone", 32'(tone_en), 0);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("prs_addr", 32'(note_addr), 0);
    check("prs_tone", 32'(tone_en), 0);
    cyc(1);
    check("prs_hold_code", 32'(note_code), 12);
    check("prs_hold_tone", 32'(tone_en), 0);
    cyc(2);
    check("prs_hold_still", 32'(tone_en), 0);
    pause = 1'b0;
    cyc(1);
    check("prs_resume", 32'(tone_en), 1);

    // song change 0 -> 3 -> 4 -> 12
    song_index = 4'd3;
    cyc(1);
    check("s3_addr", 32'(note_addr), 0);
    cyc(1);
    check("s3_code", 32'(note_code), 30);
    cyc(1);
    song_index = 4'd4;
    cyc(1);
    check("s4_addr", 32'(note_addr), 0);
    cyc(1);
    check("s4_code", 32'(note_code), 40);
    check("s4_tone", 32'(tone_en), 1);
    song_index = 4'd12;
    cyc(2);
    check("s12_done", 32'(song_done), 1);
    check("s12_tone", 32'(tone_en), 0);
    check("s12_code", 32'(note_code), 0);
    cyc(1);
    check("s12_done2", 32'(song_done), 32'(LOOP));
    check("s12_silent", 32'(tone_en), 0);

    // song 1: end marker at address 3
    song_index = 4'd1;
    cyc(2);
    check("s1_code", 32'(note_code), 20);
    cyc(15);
    check("s1_end_done", 32'(song_done), 1);
    check("s1_end_tone", 32'(tone_en), 0);
    check("s1_end_addr", 32'(note_addr), LOOP ? 0 : 3);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (song_done) pulses++;
    end
    check("s1_done_once", 32'(pulses), 0);
    check("s1_after_addr", 32'(note_addr), LOOP ? 1 : 3);
    check("s1_after_tone", 32'(tone_en), 32'(LOOP));

    // play=0, pause=0 -> IDLE
    play = 1'b0;
    cyc(1);
    check("idle_addr", 32'(note_addr), 0);
    check("idle_tone", 32'(tone_en), 0);
    check("idle_code", 32'(note_code), 0);

    // song 9: 64 notes, end of address space terminates it
    song_index = 4'd9;
    play = 1'b1;
    cyc(320);
    check("s9_addr63", 32'(note_addr), 63);
    check("s9_code63", 32'(note_code), 63);
    check("s9_tone63", 32'(tone_en), 1);
    cyc(1);
    check("s9_done", 32'(song_done), 1);
    check("s9_tone", 32'(tone_en), 0);
    check("s9_addr", 32'(note_addr), LOOP ? 0 : 63);

    // reset mid-note
    song_index = 4'd0;
    cyc(2);
    check("pre_rst_tone", 32'(tone_en), 1);
    cyc(1);
    resetn = 1'b0;
    cyc(1);
    check("mrst_code", 32'(note_code), 0);
    check("mrst_tone", 32'(tone_en), 0);
    check("mrst_addr", 32'(note_addr), 0);
    check("mrst_tick", 32'(beat_tick), 0);
    check("mrst_done", 32'(song_done), 0);
    resetn = 1'b1;
    cyc(1);
    check("post_rst_fetch", 32'(tone_en), 0);
    cyc(1);
    check("post_rst_code", 32'(note_code), 12);
    check("post_rst_tone", 32'(tone_en), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
